// File: rtl/probe_capture_ctrl.sv
// Logic-analyser style capture controller: pre/post-trigger sampling into an
// external circular RAM, followed by an ordered ready/valid readout.
module probe_capture_ctrl #(
   parameter int unsigned DATA_W     = 24,
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clock_dvi,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     probe_i,
   input  logic                  arm_i,
   input  logic                  abort_i,
   input  logic [DATA_W-1:0]     trig_value_i,
   input  logic [DATA_W-1:0]     trig_mask_i,
   input  logic [DEPTH_LOG2-1:0] post_count_i,
   output logic                  ram_we_o,
   output logic [DEPTH_LOG2-1:0] ram_waddr_o,
   output logic [DATA_W-1:0]     ram_wdata_o,
   output logic [DEPTH_LOG2-1:0] ram_raddr_o,
   input  logic [DATA_W-1:0]     ram_rdata_i,
   input  logic                  rd_start_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_W-1:0]     out_data_o,
   output logic                  out_last_o,
   output logic [2:0]            state_o,
   output logic [DEPTH_LOG2-1:0] trig_addr_o
);

   localparam int unsigned AW    = DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PREFILL = 3'd1,
      S_ARMED   = 3'd2,
      S_POST    = 3'd3,
      S_DONE    = 3'd4,
      S_READ    = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     fill_q, fill_d;
   logic [AW-1:0]     post_q, post_d;
   logic [AW-1:0]     post_cnt_q, post_cnt_d;
   logic [DATA_W-1:0] tval_q, tval_d;
   logic [DATA_W-1:0] tmask_q, tmask_d;
   logic [AW-1:0]     trig_addr_q, trig_addr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     issued_q, issued_d;
   logic [AW-1:0]     sent_q, sent_d;
   logic              issue_q, issue_d;
   logic              pend_q, pend_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              wr_idx_q, wr_idx_d;
   logic              rd_idx_q, rd_idx_d;
   logic [DATA_W-1:0] buf0_q, buf0_d;
   logic [DATA_W-1:0] buf1_q, buf1_d;

   logic              capturing;
   logic              match;
   logic              pop;
   logic              start;
   logic [2:0]        in_flight;

   assign capturing = (state_q == S_PREFILL) || (state_q == S_ARMED) || (state_q == S_POST);
   assign match     = ((probe_i ^ tval_q) & tmask_q) == '0;
   assign pop       = (cnt_q != 2'd0) && out_ready_i;
   // Buffer slots already committed next cycle: held + arriving + requested, minus the word leaving.
   assign in_flight = 3'(cnt_q) + 3'(pend_q) + 3'(issue_q) - 3'(pop);

   // Output decode straight from state registers
   assign state_o     = state_q;
   assign trig_addr_o = trig_addr_q;
   assign ram_we_o    = capturing;
   assign ram_waddr_o = wr_ptr_q;
   assign ram_wdata_o = capturing ? probe_i : '0;
   assign ram_raddr_o = rd_ptr_q;
   assign out_valid_o = (cnt_q != 2'd0);
   assign out_data_o  = rd_idx_q ? buf1_q : buf0_q;
   assign out_last_o  = out_valid_o && (&sent_q);

   // Next-state: capture sequencing, readout credit control and output buffer
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      fill_d      = fill_q;
      post_d      = post_q;
      post_cnt_d  = post_cnt_q;
      tval_d      = tval_q;
      tmask_d     = tmask_q;
      trig_addr_d = trig_addr_q;
      rd_ptr_d    = rd_ptr_q;
      issued_d    = issued_q;
      sent_d      = sent_q;
      issue_d     = 1'b0;
      pend_d      = 1'b0;
      cnt_d       = cnt_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;
      start       = 1'b0;

      if (capturing) wr_ptr_d = wr_ptr_q + AW'(1);

      case (state_q)
         S_IDLE: begin
            if (arm_i) start = 1'b1;
         end
         S_PREFILL: begin
            fill_d = fill_q + AW'(1);
            // ~post_q == DEPTH - post - 1: index of the last pre-trigger write
            if (fill_q == ~post_q) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (match) begin
               trig_addr_d = wr_ptr_q;
               post_cnt_d  = AW'(1);
               state_d     = (post_q == AW'(1)) ? S_DONE : S_POST;
            end
         end
         S_POST: begin
            if (post_cnt_q == post_q - AW'(1)) state_d = S_DONE;
            else                               post_cnt_d = post_cnt_q + AW'(1);
         end
         S_DONE: begin
            if (arm_i) begin
               start = 1'b1;
            end else if (rd_start_i) begin
               state_d  = S_READ;
               rd_ptr_d = wr_ptr_q;
               issue_d  = 1'b1;
               issued_d = CW'(1);
               sent_d   = '0;
            end
         end
         S_READ: begin
            pend_d = issue_q;
            if (issue_q) rd_ptr_d = rd_ptr_q + AW'(1);
            if ((issued_q < CW'(DEPTH)) && (in_flight <= 3'd1)) begin
               issue_d  = 1'b1;
               issued_d = issued_q + CW'(1);
            end
            if (pend_q) begin
               if (wr_idx_q) buf1_d = ram_rdata_i;
               else          buf0_d = ram_rdata_i;
               wr_idx_d = ~wr_idx_q;
            end
            if (pop) begin
               rd_idx_d = ~rd_idx_q;
               sent_d   = sent_q + AW'(1);
            end
            cnt_d = cnt_q + 2'(pend_q) - 2'(pop);
            if (pop && (&sent_q)) begin
               state_d = S_IDLE;
               issue_d = 1'b0;
               pend_d  = 1'b0;
               cnt_d   = 2'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         state_d  = S_PREFILL;
         tval_d   = trig_value_i;
         tmask_d  = trig_mask_i;
         post_d   = (post_count_i == '0) ? AW'(1) : post_count_i;
         wr_ptr_d = '0;
         fill_d   = '0;
      end

      if (abort_i) begin
         state_d  = S_IDLE;
         issue_d  = 1'b0;
         pend_d   = 1'b0;
         cnt_d    = 2'd0;
         wr_idx_d = 1'b0;
         rd_idx_d = 1'b0;
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clock_dvi) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         post_q      <= '0;
         post_cnt_q  <= '0;
         tval_q      <= '0;
         tmask_q     <= '0;
         trig_addr_q <= '0;
         rd_ptr_q    <= '0;
         issued_q    <= '0;
         sent_q      <= '0;
         issue_q     <= 1'b0;
         pend_q      <= 1'b0;
         cnt_q       <= 2'd0;
         wr_idx_q    <= 1'b0;
         rd_idx_q    <= 1'b0;
         buf0_q      <= '0;
         buf1_q      <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         fill_q      <= fill_d;
         post_q      <= post_d;
         post_cnt_q  <= post_cnt_d;
         tval_q      <= tval_d;
         tmask_q     <= tmask_d;
         trig_addr_q <= trig_addr_d;
         rd_ptr_q    <= rd_ptr_d;
         issued_q    <= issued_d;
         sent_q      <= sent_d;
         issue_q     <= issue_d;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
      end
   end

endmodule

// File: tb/tb_probe_capture_ctrl.sv
// Self-checking bench for probe_capture_ctrl with a 16-deep RAM model.
`timescale 1ns/1ps
module tb_probe_capture_ctrl;

   localparam int unsigned DW    = 24;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] probe;
   logic          arm;
   logic          abort_r;
   logic [DW-1:0] trig_value;
   logic [DW-1:0] trig_mask;
   logic [AW-1:0] post_count;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_rdata;
   logic          rd_start;
   logic          valid;
   logic          ready;
   logic [DW-1:0] data;
   logic          last;
   logic [2:0]    state;
   logic [AW-1:0] trig_addr;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] exp_q [$];
   int            n_pass  = 0;
   int            n_total = 0;

   always #5 clk = ~clk;

   probe_capture_ctrl #(.DATA_W(DW), .DEPTH_LOG2(AW)) dut (
      .clock_dvi   (clk),
      .reset       (rst),
      .probe_i     (probe),
      .arm_i       (arm),
      .abort_i     (abort_r),
      .trig_value_i(trig_value),
      .trig_mask_i (trig_mask),
      .post_count_i(post_count),
      .ram_we_o    (ram_we),
      .ram_waddr_o (ram_waddr),
      .ram_wdata_o (ram_wdata),
      .ram_raddr_o (ram_raddr),
      .ram_rdata_i (ram_rdata),
      .rd_start_i  (rd_start),
      .out_valid_o (valid),
      .out_ready_i (ready),
      .out_data_o  (data),
      .out_last_o  (last),
      .state_o     (state),
      .trig_addr_o (trig_addr)
   );

   // Sample RAM with 1-cycle registered read
   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      ram_rdata <= mem[ram_raddr];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one capture with probe = 0,1,2,... from the first PREFILL cycle.
   task automatic run_capture(input logic [DW-1:0] tv, input logic [DW-1:0] tm,
                              input logic [AW-1:0] pc, input int trig_k, input int reset_at);
      int pe;
      int pre;
      logic [2:0] es;
      pe  = (pc == 0) ? 1 : int'(pc);
      pre = DEPTH - pe;
      exp_q.delete();
      trig_value = tv; trig_mask = tm; post_count = pc; arm = 1'b1; probe = 24'hABCDEF;
      step();
      arm = 1'b0;
      trig_value = ~tv; trig_mask = '1; post_count = 4'(pc + 3);
      for (int k = 0; k < trig_k + pe; k++) begin
         probe = 24'(k);
         #1;
         es = (k < pre) ? 3'd1 : ((k <= trig_k) ? 3'd2 : 3'd3);
         n_total++;
         if (state !== es) $display("FAIL cap_state k=%0d got %0d exp %0d", k, state, es);
         else n_pass++;
         n_total++;
         if (ram_we !== 1'b1 || ram_waddr !== 4'(k) || ram_wdata !== 24'(k))
            $display("FAIL cap_write k=%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h",
                     k, ram_we, ram_waddr, ram_wdata, k % DEPTH, k);
         else n_pass++;
         arm      = (k == pre + 1) && (k < trig_k);
         rd_start = arm;
         exp_q.push_back(24'(k));
         if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
         if (k == reset_at) begin
            rst = 1'b1; arm = 1'b0; rd_start = 1'b0;
            step();
            rst = 1'b0;
            return;
         end
         step();
      end
      arm = 1'b0; rd_start = 1'b0; probe = 24'h5A5A5A;
      #1;
      n_total++;
      if (state !== 3'd4 || ram_we !== 1'b0) $display("FAIL cap_done got st=%0d we=%b exp st=4 we=0", state, ram_we);
      else n_pass++;
      n_total++;
      if (trig_addr !== 4'(trig_k)) $display("FAIL trig_addr got %0d exp %0d", trig_addr, trig_k % DEPTH);
      else n_pass++;
   endtask

   // Read out the capture and compare against the scoreboard queue.
   task automatic run_readout(input bit toggle, input int abort_at);
      int words;
      int cyc;
      bit done;
      bit stall_v;
      logic [DW-1:0] stall_d;
      logic stall_l;
      logic [DW-1:0] ed;
      logic exp_last;
      words = 0; cyc = 0; done = 0; stall_v = 0; stall_d = '0; stall_l = 1'b0;
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      n_total++;
      if (state !== 3'd5) $display("FAIL read_enter got %0d exp 5", state);
      else n_pass++;
      while (!done && cyc < 300) begin
         ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         #1;
         if (stall_v) begin
            n_total++;
            if (valid !== 1'b1 || data !== stall_d || last !== stall_l)
               $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b", valid, data, last, stall_d, stall_l);
            else n_pass++;
         end
         if (valid === 1'b1 && ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
               $display("FAIL extra_word got %h exp none", data);
               done = 1;
            end else begin
               ed       = exp_q.pop_front();
               exp_last = (exp_q.size() == 0);
               if (data !== ed || last !== exp_last)
                  $display("FAIL read_word %0d got d=%h l=%b exp d=%h l=%b", words, data, last, ed, exp_last);
               else n_pass++;
               if (exp_last) done = 1;
            end
            words++;
         end
         if (abort_at >= 0 && words == abort_at) begin
            abort_r = 1'b1;
            step();
            abort_r = 1'b0; ready = 1'b0;
            n_total++;
            if (state !== 3'd0 || valid !== 1'b0) $display("FAIL read_abort got st=%0d v=%b exp st=0 v=0", state, valid);
            else n_pass++;
            return;
         end
         stall_v = (valid === 1'b1) && !ready;
         stall_d = data;
         stall_l = last;
         step();
         cyc++;
      end
      ready = 1'b0;
      n_total++;
      if (!done) $display("FAIL read_timeout got %0d words exp %0d", words, DEPTH);
      else n_pass++;
      n_total++;
      if (state !== 3'd0 || valid !== 1'b0) $display("FAIL read_end got st=%0d v=%b exp st=0 v=0", state, valid);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1; probe = 24'h123456;
      step(); step();
      rst = 1'b0;
      #1;
      n_total++;
      if (state !== 3'd0 || ram_we !== 1'b0 || valid !== 1'b0 || last !== 1'b0)
         $display("FAIL reset_ctrl got st=%0d we=%b v=%b l=%b exp all 0", state, ram_we, valid, last);
      else n_pass++;
      n_total++;
      if (ram_waddr !== '0 || ram_wdata !== '0 || ram_raddr !== '0 || data !== '0 || trig_addr !== '0)
         $display("FAIL reset_data got wa=%0d wd=%h ra=%0d d=%h ta=%0d exp all 0",
                  ram_waddr, ram_wdata, ram_raddr, data, trig_addr);
      else n_pass++;
   endtask

   task automatic test_idle_ignores();
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      n_total++;
      if (state !== 3'd0 || valid !== 1'b0) $display("FAIL idle_rd_start got st=%0d v=%b exp st=0 v=0", state, valid);
      else n_pass++;
      abort_r = 1'b1; arm = 1'b1;
      step();
      abort_r = 1'b0; arm = 1'b0;
      n_total++;
      if (state !== 3'd0 || ram_we !== 1'b0 || valid !== 1'b0)
         $display("FAIL abort_arm got st=%0d we=%b v=%b exp st=0 we=0 v=0", state, ram_we, valid);
      else n_pass++;
   endtask

   task automatic test_capture_basic();
      run_capture(24'h000020, 24'hFFFFFF, 4'd4, 32, -1);
      run_readout(1'b0, -1);
   endtask

   task automatic test_stall_readout();
      run_capture(24'h000020, 24'hFFFFFF, 4'd4, 32, -1);
      run_readout(1'b1, -1);
   endtask

   task automatic test_mask_zero();
      run_capture(24'h123456, 24'h000000, 4'd0, 15, -1);
      run_readout(1'b1, -1);
   endtask

   task automatic test_prefill_no_trigger();
      // Sample 5 matches but falls in PREFILL; sample 0x15 is the first armed match.
      run_capture(24'h000005, 24'h00000F, 4'd4, 21, -1);
      run_readout(1'b0, -1);
   endtask

   task automatic test_rearm_from_done();
      run_capture(24'h000020, 24'hFFFFFF, 4'd4, 32, -1);
      run_capture(24'h000018, 24'hFFFFFF, 4'd2, 24, -1);
      run_readout(1'b1, -1);
   endtask

   task automatic test_abort_readout();
      run_capture(24'h000020, 24'hFFFFFF, 4'd4, 32, -1);
      run_readout(1'b0, 5);
      run_capture(24'h000011, 24'hFFFFFF, 4'd3, 17, -1);
      run_readout(1'b1, -1);
   endtask

   task automatic test_reset_in_post();
      run_capture(24'h00001C, 24'hFFFFFF, 4'd8, 28, 30);
      n_total++;
      if (state !== 3'd0 || ram_we !== 1'b0 || valid !== 1'b0 || last !== 1'b0 || trig_addr !== '0)
         $display("FAIL post_reset_ctrl got st=%0d we=%b v=%b l=%b ta=%0d exp all 0",
                  state, ram_we, valid, last, trig_addr);
      else n_pass++;
      n_total++;
      if (ram_waddr !== '0 || ram_wdata !== '0 || ram_raddr !== '0 || data !== '0)
         $display("FAIL post_reset_data got wa=%0d wd=%h ra=%0d d=%h exp all 0", ram_waddr, ram_wdata, ram_raddr, data);
      else n_pass++;
      run_capture(24'h000020, 24'hFFFFFF, 4'd4, 32, -1);
      run_readout(1'b0, -1);
   endtask

   initial begin
      rst = 1'b1; probe = '0; arm = 1'b0; abort_r = 1'b0; trig_value = '0; trig_mask = '0;
      post_count = '0; rd_start = 1'b0; ready = 1'b0;
      test_reset();
      test_idle_ignores();
      test_capture_basic();
      test_stall_readout();
      test_mask_zero();
      test_prefill_no_trigger();
      test_rearm_from_done();
      test_abort_readout();
      test_reset_in_post();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/probe_capture_ctrl.md
PROBE_CAPTURE_CTRL -- requirements
Module: probe_capture_ctrl

Interface
REQ-001 Parameter DATA_W, default 24, width of the probed shader datapath word.
REQ-002 Parameter DEPTH_LOG2, default 10, log2 of the sample RAM depth (DEPTH = 2**DEPTH_LOG2).
REQ-003 clock_dvi  in  1  pixel clock; sole clock, all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 probe_i  in  DATA_W  sampled datapath word, one sample per cycle.
REQ-006 arm_i  in  1  single-cycle request to start a capture.
REQ-007 abort_i  in  1  single-cycle request to cancel any activity.
REQ-008 trig_value_i / trig_mask_i  in  DATA_W each  trigger compare value and bit mask (1 = compared).
REQ-009 post_count_i  in  DEPTH_LOG2  samples stored from the trigger sample onward.
REQ-010 ram_we_o, ram_waddr_o, ram_wdata_o  out  1 / DEPTH_LOG2 / DATA_W  sample RAM write port.
REQ-011 ram_raddr_o  out  DEPTH_LOG2; ram_rdata_i  in  DATA_W; the RAM has fixed 1-cycle read latency.
REQ-012 rd_start_i  in  1  single-cycle readout request.
REQ-013 out_valid_o, out_ready_i, out_data_o, out_last_o  out/in/out/out  1/1/DATA_W/1  readout stream.
REQ-014 state_o  out  3  encoding IDLE=0, PREFILL=1, ARMED=2, POST=3, DONE=4, READ=5.
REQ-015 trig_addr_o  out  DEPTH_LOG2  RAM address of the trigger sample, valid in DONE and READ.

Function
REQ-016 Trigger match = ((probe_i ^ trig_value_i) & trig_mask_i) == 0; mask of all zeros matches every cycle.
REQ-017 In IDLE, arm_i captures trig_value_i, trig_mask_i, post_count_i (0 treated as 1), clears wr_ptr and fill count, and enters PREFILL.
REQ-018 In PREFILL, ARMED and POST, ram_we_o = 1 every cycle with ram_wdata_o = probe_i and ram_waddr_o = wr_ptr; wr_ptr increments mod DEPTH.
REQ-019 PREFILL -> ARMED once DEPTH - post_count samples are written; no trigger is evaluated in PREFILL.
REQ-020 In ARMED, a match stores the current sample as trigger sample, latches trig_addr_o = wr_ptr and enters POST in the same cycle's update; writing continues with wrap-around.
REQ-021 POST counts the trigger sample as sample 1; after post_count samples total, ram_we_o drops and state enters DONE; with post_count = 1 ARMED goes directly to DONE.
REQ-022 In DONE the oldest sample is at wr_ptr (= trig_addr_o + post_count mod DEPTH); arm_i re-arms exactly as from IDLE.
REQ-023 rd_start_i in DONE enters READ; rd_start_i in any other state is ignored.
REQ-024 READ issues ram_raddr_o from wr_ptr upward (mod DEPTH) for exactly DEPTH words; the 1-cycle RAM latency is absorbed by a 2-entry output buffer so no word is lost or duplicated under any out_ready_i pattern.
REQ-025 A stream word transfers when out_valid_o and out_ready_i are both 1; out_data_o and out_last_o hold stable while out_valid_o = 1 and out_ready_i = 0.
REQ-026 out_last_o = 1 only on the DEPTH-th word; its transfer returns the state to IDLE.
REQ-027 arm_i in PREFILL, ARMED, POST or READ is ignored.
REQ-028 abort_i in any state returns to IDLE next cycle, drops ram_we_o and out_valid_o, flushes the output buffer; abort_i wins over simultaneous arm_i or rd_start_i.

Reset
REQ-029 reset forces state IDLE, ram_we_o = 0, out_valid_o = 0, out_last_o = 0, wr_ptr = 0, trig_addr_o = 0, all data/address outputs 0, output buffer empty.
REQ-030 reset asserted mid-capture or mid-readout takes effect at the next edge and overrides every other input.

Verification (DEPTH_LOG2 = 4, DEPTH = 16)
REQ-031 post_count 4, mask 0xFFFFFF, value 0x000020, probe = cycle counter starting 0 at arm -> PREFILL 12 writes, trigger at sample 0x20, trig_addr_o = 0, DONE after samples 0x20..0x23.
REQ-032 Readout with out_ready_i held 1 -> 16 words 0x14..0x23 in order, out_last_o on 0x23, state IDLE afterwards.
REQ-033 Same readout with out_ready_i toggling 1,0,0,1 pattern -> identical 16-word sequence, no drops or duplicates, data stable during stalls.
REQ-034 mask 0, post_count 0 -> treated as 1; trigger on first ARMED cycle (sample 15), DONE next cycle, trig_addr_o = 15.
REQ-035 abort_i together with arm_i in IDLE, and abort_i at readout word 5 -> state stays/returns IDLE, out_valid_o = 0 next cycle.
REQ-036 reset asserted during POST -> all outputs at REQ-029 values next cycle; fresh arm then captures normally.
